// File: rtl/seq_pkg.sv
// Shared types and default widths for the serial pattern transmitter.
// SEQ_TX_PARITY_EN enables the per-pattern even-parity bit.
package seq_pkg;

  localparam int SEQ_W_DEF = 4;
  localparam int CNT_W_DEF = 4;
  localparam int GAP_W_DEF = 3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_PARITY,
    TX_GAP
  } tx_state_t;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load MSB-first shift register with bit counter.
// Optional parity output when SEQ_TX_PARITY_EN is defined.
module seq_piso #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         bit_out,
`ifdef SEQ_TX_PARITY_EN
  output logic         par,
`endif
  output logic         last_bit
);

  localparam int IW = $clog2(W);

  logic [W-1:0]  sreg;
  logic [IW-1:0] cnt;

  // Rotate rather than shift so the pattern is intact for the next repetition
  always_ff @(posedge clk) begin
    if (!clr) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= din;
      cnt  <= '0;
    end else if (shift) begin
      sreg <= {sreg[W-2:0], sreg[W-1]};
      cnt  <= last_bit ? '0 : cnt + 1'b1;
    end
  end

  assign bit_out  = sreg[W-1];
  assign last_bit = (cnt == IW'(W - 1));

`ifdef SEQ_TX_PARITY_EN
  assign par = ^sreg;
`endif

endmodule

// File: rtl/seq_transmitter.sv
// Serial pattern generator: repeats a captured pattern with idle gaps.
// Define SEQ_TX_PARITY_EN to append an even-parity bit per pattern.
module seq_transmitter
  import seq_pkg::*;
#(
  parameter int   SEQ_W      = SEQ_W_DEF,
  parameter int   CNT_W      = CNT_W_DEF,
  parameter int   GAP_W      = GAP_W_DEF,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [SEQ_W-1:0] user_seq,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             E,
  output logic             E_valid,
  output logic             busy,
  output logic             done
);

  tx_state_t        state, state_nx;
  logic [CNT_W-1:0] reps_left, reps_nx;
  logic [GAP_W-1:0] gap_reg, gap_nx;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;
  logic             done_nx;
  logic             load, shift, rep_end;
  logic             bit_out, last_bit;
`ifdef SEQ_TX_PARITY_EN
  logic             par;
`endif

  seq_piso #(.W(SEQ_W)) u_piso (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .shift    (shift),
    .din      (user_seq),
    .bit_out  (bit_out),
`ifdef SEQ_TX_PARITY_EN
    .par      (par),
`endif
    .last_bit (last_bit)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      state     <= TX_IDLE;
      reps_left <= '0;
      gap_reg   <= '0;
      gap_cnt   <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      reps_left <= reps_nx;
      gap_reg   <= gap_nx;
      gap_cnt   <= gap_cnt_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    reps_nx    = reps_left;
    gap_nx     = gap_reg;
    gap_cnt_nx = gap_cnt;
    done_nx    = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    rep_end    = 1'b0;
    unique case (state)
      TX_IDLE: begin
        if (start) begin
          load     = 1'b1;
          reps_nx  = repeat_n;
          gap_nx   = gap;
          state_nx = TX_SEND;
        end
      end
      TX_SEND: begin
        shift = 1'b1;
        if (last_bit) begin
`ifdef SEQ_TX_PARITY_EN
          state_nx = TX_PARITY;
`else
          rep_end = 1'b1;
`endif
        end
      end
`ifdef SEQ_TX_PARITY_EN
      TX_PARITY: rep_end = 1'b1;
`endif
      TX_GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          gap_cnt_nx = '0;
          reps_nx    = reps_left - 1'b1;
          state_nx   = TX_SEND;
        end else begin
          gap_cnt_nx = gap_cnt - 1'b1;
        end
      end
      default: state_nx = TX_IDLE;
    endcase
    // End of one pattern: finish, pause, or restart with no bubble
    if (rep_end) begin
      if (reps_left == '0) begin
        state_nx = TX_IDLE;
        done_nx  = 1'b1;
      end else if (gap_reg != '0) begin
        state_nx   = TX_GAP;
        gap_cnt_nx = gap_reg;
      end else begin
        state_nx = TX_SEND;
        reps_nx  = reps_left - 1'b1;
      end
    end
  end

  assign busy    = (state != TX_IDLE);
  assign E_valid = busy;

  always_comb begin
    E = IDLE_LEVEL;
    if (state == TX_SEND) E = bit_out;
`ifdef SEQ_TX_PARITY_EN
    if (state == TX_PARITY) E = par;
`endif
  end

endmodule

// File: tb/tb_seq_transmitter.sv
// Bench for seq_transmitter: vector table plus scoreboard queue of bits.
// Also covers reset, abort and mid-stream start/input changes.
module tb_seq_transmitter;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [3:0] user_seq;
  logic [3:0] repeat_n;
  logic [2:0] gap;
  logic       E, E_valid, busy, done;

  int n_vec  = 0;
  int n_miss = 0;
  logic q[$];

`ifdef SEQ_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  seq_transmitter dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .user_seq (user_seq),
    .repeat_n (repeat_n),
    .gap      (gap),
    .E        (E),
    .E_valid  (E_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] seq;
    logic [3:0] rep;
    logic [2:0] gp;
    int         inject;
    int         exp_busy;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] s, input int rep,
                          input int gp);
    for (int r = 0; r <= rep; r++) begin
      for (int k = 3; k >= 0; k--) q.push_back(s[k]);
      if (PB != 0) q.push_back(^s);
      if (r < rep)
        for (int g = 0; g < gp; g++) q.push_back(1'b0);
    end
  endtask

  task automatic start_tx(input logic [3:0] s, input logic [3:0] rep,
                          input logic [2:0] gp);
    user_seq = s;
    repeat_n = rep;
    gap      = gp;
    start    = 1'b1;
    push_exp(s, int'(rep), int'(gp));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic watch(input string nm, input int exp_busy,
                       input int inject);
    int  cyc = 0;
    int  bcnt = 0;
    bit  fin = 0;
    logic b;
    while (!fin && cyc < 300) begin
      if (E_valid) begin
        if (q.size() == 0) chk({nm, " extra bit"}, 1, 0);
        else begin
          b = q.pop_front();
          chk({nm, " bit"}, E, b);
        end
      end
      if (busy) bcnt++;
      if (done) begin
        fin = 1;
        chk({nm, " busy_len"}, bcnt, exp_busy);
        chk({nm, " end_state"}, {E, E_valid, busy}, 3'b000);
        chk({nm, " q_left"}, q.size(), 0);
      end else begin
        if (cyc == inject) begin
          start    = 1'b1;
          user_seq = ~user_seq;
          repeat_n = 4'hF;
          gap      = 3'd7;
        end
        if (inject >= 0 && cyc == inject + 1) start = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk({nm, " timeout"}, 1, 0);
  endtask

  initial begin
    vt[0] = '{4'b1001, 4'd0,  3'd0, -1, 4};
    vt[1] = '{4'b1100, 4'd1,  3'd2, -1, 10};
    vt[2] = '{4'b1011, 4'd2,  3'd0, -1, 12};
    vt[3] = '{4'b1001, 4'd0,  3'd5, -1, 4};
    vt[4] = '{4'b0110, 4'd3,  3'd1, -1, 19};
    vt[5] = '{4'b1011, 4'd1,  3'd0,  2, 8};
    vt[6] = '{4'b0001, 4'd1,  3'd7, -1, 15};
    vt[7] = '{4'b1010, 4'd15, 3'd0, -1, 64};

    clr      = 1'b0;
    start    = 1'b1;
    user_seq = 4'hF;
    repeat_n = 4'd2;
    gap      = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset", {E, E_valid, busy, done}, 4'b0000);
    end
    clr   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("post_reset", {E, E_valid, busy, done}, 4'b0000);

    // Each vector starts in the done cycle of the previous one
    for (int i = 0; i < 8; i++) begin
      start_tx(vt[i].seq, vt[i].rep, vt[i].gp);
      watch($sformatf("vec%0d", i),
            vt[i].exp_busy + PB * (int'(vt[i].rep) + 1), vt[i].inject);
    end
    @(negedge clk);
    chk("done_pulse", {done, busy}, 2'b00);

    // Abort during bit 2 of 1001
    start_tx(4'b1001, 4'd0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      chk("abort_bit", E, q.pop_front());
      if (k < 2) @(negedge clk);
    end
    clr = 1'b0;
    @(negedge clk);
    chk("abort", {E, E_valid, busy, done}, 4'b0000);
    clr = 1'b1;
    q.delete();
    @(negedge clk);
    chk("abort_nodone", {E_valid, busy, done}, 3'b000);
    start_tx(4'b1001, 4'd0, 3'd0);
    watch("after_abort", 4 + PB, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seq_transmitter.md
Name: seq_transmitter

Overview:
- Serial pattern generator; the transmit end of the 1-bit serial stream E that the sequence detector consumes.
- On a start pulse it captures a SEQ_W-bit pattern and shifts it out MSB first, one bit per clock.
- It repeats the pattern a programmable number of times, with an optional idle gap between repetitions.
- Used as a stimulus source and loopback partner for the detector, and as a standalone pattern emitter.

Parameters:
- SEQ_W, 4, pattern width in bits (must be >= 2).
- CNT_W, 4, width of the repeat-count input.
- GAP_W, 3, width of the gap-length input.
- IDLE_LEVEL, 1'b0, level driven on E when no stream bit is being sent.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- clr  in  1  reset, synchronous, active-low (0 = reset).
- start  in  1  one-cycle request to begin transmission.
- user_seq  in  SEQ_W  pattern to transmit, MSB sent first.
- repeat_n  in  CNT_W  extra repetitions; total transmissions = repeat_n+1.
- gap  in  GAP_W  idle-bit cycles inserted between repetitions.
- E  out  1  serial data bit.
- E_valid  out  1  high while E carries a stream bit (pattern, parity or gap).
- busy  out  1  high from the cycle after start is accepted until the last bit ends.
- done  out  1  one-cycle pulse after the final bit.

Behaviour:
- Reset (clr=0 at an edge) forces: E=IDLE_LEVEL, E_valid=0, busy=0, done=0, state=IDLE, counters=0.
- Reset mid-operation aborts the transfer immediately. No done pulse is produced.
- States: IDLE, SEND, PARITY (only with the optional feature), GAP.
- IDLE:
  - start=1 at edge t captures user_seq, repeat_n and gap into internal registers and moves to SEND.
  - At t+1: E=user_seq[SEQ_W-1], E_valid=1, busy=1. Start-to-first-bit latency is 1 cycle.
- SEND:
  - Bit index k (0..SEQ_W-1) drives E=seq_reg[SEQ_W-1-k] for exactly one cycle each.
  - After bit SEQ_W-1: PARITY if enabled; else GAP if reps_left>0 and gap>0; else SEND (next repetition back-to-back, no bubble) if reps_left>0; else IDLE.
- GAP:
  - E=IDLE_LEVEL, E_valid=1 for exactly gap cycles, then SEND.
  - reps_left decrements when each new repetition starts.
- Completion:
  - First cycle after the final bit: state=IDLE, busy=0, E_valid=0, E=IDLE_LEVEL, done=1 for one cycle only.
  - start is accepted in that same done cycle; the next first bit follows one cycle later.
- start while busy=1 is ignored. Changes to user_seq, repeat_n or gap while busy have no effect.
- repeat_n=0 gives a single transmission. gap is ignored when repeat_n=0.
- Total busy cycles = (repeat_n+1)*(SEQ_W[+1 with parity]) + repeat_n*gap.
- Counters never wrap. reps_left loads repeat_n (max 2^CNT_W-1) and counts down to 0.

Optional Feature:
- Macro: SEQ_TX_PARITY_EN.
- Defined: after every SEQ_W pattern bits, the block enters PARITY for one cycle. E = even parity (XOR of seq_reg), E_valid=1.
- Undefined: the PARITY state and its logic are absent; SEND goes directly to GAP, SEND or IDLE.

Decomposition:
- Package seq_pkg holds:
  - typedef enum logic [1:0] tx_state_t {TX_IDLE, TX_SEND, TX_PARITY, TX_GAP};
  - default width constants SEQ_W_DEF=4, CNT_W_DEF=4, GAP_W_DEF=3.
- One sub-module: seq_piso, a parallel-load, MSB-first shift register with a bit counter.
  - Inputs: load, shift.
  - Outputs: bit_out, last_bit.
  - The FSM in seq_transmitter drives it.

Test Plan:
- Reset: hold clr=0 for 3 cycles with start=1 -> E=0, E_valid=0, busy=0, done=0 throughout.
- Single pattern: user_seq=4'b1001, repeat_n=0, start pulsed at edge 2 -> E=1,0,0,1 with E_valid=1 at edges 3-6; done=1 and busy=0 at edge 7.
- Repeat with gap: user_seq=4'b1100, repeat_n=1, gap=2 -> E=1,1,0,0,0,0,1,1,0,0 over 10 cycles, E_valid high for all 10; done=1 on cycle 11.
- Back-to-back and ignore rules:
  - user_seq=4'b1011, repeat_n=2, gap=0 -> 12 contiguous bits 101110111011.
  - start and a new user_seq applied mid-stream -> output unchanged.
- Abort: clr=0 during bit 2 of 4'b1001 -> next edge E=0, E_valid=0, busy=0, no done. A fresh start afterwards transmits the full pattern.
- Loopback: drive the detector's E from this E with user_seq=4'b1001 on both -> detector Y asserts exactly once per transmitted 1001 occurrence. With SEQ_TX_PARITY_EN defined, the parity bit after 1001 is 0.
